// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754-format floating-point multiplier with a
// valid/ready handshake and a global stall. S1 unpacks and classifies the operands,
// S2 forms the significand product, and S3 normalises, rounds (to nearest even),
// packs the result and raises the exception flags.
// Optional build macro FP_MUL_SUBNORMAL_EN enables gradual underflow. When it is
// undefined, subnormal inputs are read as zero and tiny results flush to zero.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_inexact,
  output logic                 out_invalid
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int SW1  = SW + 1;
  localparam int PW   = 2 * SW;
  localparam int XW   = EXP_W + 2;
  localparam int LZW  = $clog2(PW + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             nan;
    logic             snan;
    logic             inf;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sig;
  } op_t;

  function automatic op_t unpack(input logic [W-1:0] x);
    op_t o;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e      = x[W-2 -: EXP_W];
    f      = x[MAN_W-1:0];
    o.nan  = (&e) && (|f);
    o.snan = (&e) && (|f) && !f[MAN_W-1];
    o.inf  = (&e) && !(|f);
`ifdef FP_MUL_SUBNORMAL_EN
    // Subnormals carry a leading 0 and behave as if the exponent were 1
    o.zero = (e == '0) && !(|f);
    o.sig  = {(e != '0), f};
    o.exp  = (e == '0) ? EXP_W'(1) : e;
`else
    o.zero = (e == '0);
    o.sig  = {1'b1, f};
    o.exp  = e;
`endif
    return o;
  endfunction

  function automatic logic [SW:0] round_rne(input logic [SW-1:0] kept,
                                            input logic g, input logic r, input logic s);
    return {1'b0, kept} + SW1'(g & (r | s | kept[0]));
  endfunction

  function automatic logic [W-1:0] sat_inf(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  logic advance;

  logic                 vld_p0, vld_p1, vld_p2;
  logic                 sign_p0, sign_p1;
  logic signed [XW-1:0] exp_p0, exp_p1;
  logic [SW-1:0]        siga_p0, sigb_p0;
  logic [PW-1:0]        prod_p1;
  logic                 sp_p0, sp_p1;
  logic [W-1:0]         sp_res_p0, sp_res_p1;
  logic                 sp_inv_p0, sp_inv_p1;
  logic [W-1:0]         res_p2;
  logic                 ov_p2, un_p2, ix_p2, iv_p2;

  op_t                  ua, ub;
  logic                 s1_sign, s1_sp, s1_sp_inv;
  logic signed [XW-1:0] s1_exp;
  logic [W-1:0]         s1_sp_res;

  logic [LZW-1:0]       s3_lz;
  logic [PW-1:0]        s3_norm, s3_shv;
  int                   s3_er, s3_ef;
  logic                 s3_tiny, s3_lost, s3_g, s3_rb, s3_st, s3_inx;
  logic [SW-1:0]        s3_kept;
  logic [SW:0]          s3_kr;
  logic [MAN_W-1:0]     s3_frac;
  logic [W-1:0]         s3_res;
  logic                 s3_ov, s3_un, s3_ix, s3_iv;

  // Global stall: every stage moves only when the output slot is free or draining
  always_comb advance = !vld_p2 || out_ready;

  assign in_ready      = advance;
  assign out_valid     = vld_p2;
  assign out_result    = res_p2;
  assign out_overflow  = ov_p2;
  assign out_underflow = un_p2;
  assign out_inexact   = ix_p2;
  assign out_invalid   = iv_p2;

  // S1 combinational: classify operands, result sign, exponent sum, special result
  always_comb begin
    ua        = unpack(in_a);
    ub        = unpack(in_b);
    s1_sign   = in_a[W-1] ^ in_b[W-1];
    s1_exp    = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - $signed(XW'(BIAS));
    s1_sp     = ua.nan | ua.inf | ua.zero | ub.nan | ub.inf | ub.zero;
    s1_sp_inv = 1'b0;
    s1_sp_res = {s1_sign, {(W-1){1'b0}}};
    if (ua.nan || ub.nan) begin
      s1_sp_res = QNAN;
      s1_sp_inv = ua.snan | ub.snan;
    end else if ((ua.inf && ub.zero) || (ub.inf && ua.zero)) begin
      s1_sp_res = QNAN;
      s1_sp_inv = 1'b1;
    end else if (ua.inf || ub.inf) begin
      s1_sp_res = sat_inf(s1_sign);
    end
  end

  // S3 combinational: normalise, denormalise if tiny, round, pack and flag
  always_comb begin
    s3_lz = LZW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (prod_p1[i]) s3_lz = LZW'(PW - 1 - i);
    end
    s3_norm = prod_p1 << s3_lz;
    s3_er   = int'(exp_p1) + 1 - int'(s3_lz);
    s3_tiny = (s3_er < 1);
    s3_shv  = s3_norm;
    s3_lost = 1'b0;
`ifdef FP_MUL_SUBNORMAL_EN
    if (s3_tiny) begin
      if (1 - s3_er >= MAN_W + 2) begin
        s3_shv  = '0;
        s3_lost = |s3_norm;
      end else begin
        s3_shv  = s3_norm >> (1 - s3_er);
        s3_lost = |(s3_norm << (PW - (1 - s3_er)));
      end
    end
`endif
    s3_kept = s3_shv[PW-1 -: SW];
    s3_g    = s3_shv[MAN_W];
    s3_rb   = s3_shv[MAN_W-1];
    s3_st   = (|s3_shv[MAN_W-2:0]) | s3_lost;
    s3_inx  = s3_g | s3_rb | s3_st;
    s3_kr   = round_rne(s3_kept, s3_g, s3_rb, s3_st);
    s3_frac = s3_kr[MAN_W-1:0];
    s3_ef   = s3_er;
    if (s3_kr[SW]) begin
      s3_frac = s3_kr[MAN_W:1];
      s3_ef   = s3_er + 1;
    end
    s3_res = {sign_p1, EXP_W'(s3_ef), s3_frac};
    s3_ov  = 1'b0;
    s3_un  = 1'b0;
    s3_ix  = s3_inx;
    s3_iv  = 1'b0;
    if (sp_p1) begin
      s3_res = sp_res_p1;
      s3_ix  = 1'b0;
      s3_iv  = sp_inv_p1;
    end else if (s3_tiny) begin
`ifdef FP_MUL_SUBNORMAL_EN
      // A rounding carry into the implicit bit lands on the smallest normal exponent
      s3_res = {sign_p1, EXP_W'(s3_kr[MAN_W]), s3_kr[MAN_W-1:0]};
      s3_un  = s3_inx;
`else
      s3_res = {sign_p1, {(W-1){1'b0}}};
      s3_un  = 1'b1;
      s3_ix  = 1'b1;
`endif
    end else if (s3_ef >= EMAX) begin
      s3_res = sat_inf(sign_p1);
      s3_ov  = 1'b1;
      s3_ix  = 1'b1;
    end
  end

  // Stage valid bits: cleared asynchronously, shifted together on advance
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
    end
  end

  // S1/S2 datapath registers, held during a stall
  always_ff @(posedge CLK) begin
    if (advance) begin
      // S1 boundary: unpacked operands
      sign_p0   <= s1_sign;
      exp_p0    <= s1_exp;
      siga_p0   <= ua.sig;
      sigb_p0   <= ub.sig;
      sp_p0     <= s1_sp;
      sp_res_p0 <= s1_sp_res;
      sp_inv_p0 <= s1_sp_inv;
      // S2 boundary: significand product
      sign_p1   <= sign_p0;
      exp_p1    <= exp_p0;
      prod_p1   <= PW'(siga_p0) * PW'(sigb_p0);
      sp_p1     <= sp_p0;
      sp_res_p1 <= sp_res_p0;
      sp_inv_p1 <= sp_inv_p0;
    end
  end

  // S3 boundary: output slot, cleared by reset and held while stalled
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      ov_p2  <= 1'b0;
      un_p2  <= 1'b0;
      ix_p2  <= 1'b0;
      iv_p2  <= 1'b0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      res_p2 <= s3_res;
      ov_p2  <= s3_ov;
      un_p2  <= s3_un;
      ix_p2  <= s3_ix;
      iv_p2  <= s3_iv;
    end
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits.
REQ-002 Parameter MAN_W, default 23, stored mantissa (fraction) width; operand width W = 1+EXP_W+MAN_W.
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a, in_b  input  W each  IEEE-754-format operands (sign, exponent, fraction).
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 out_result  output  W  product.
REQ-011 out_overflow, out_underflow, out_inexact, out_invalid  output  1 each  exception flags, qualified by out_valid.

Function
REQ-012 Three register stages: S1 unpack/classify/sign/exponent sum; S2 (MAN_W+1)x(MAN_W+1) significand product; S3 normalise, round, pack, flag.
REQ-013 Transfer in on rising edge when in_valid && in_ready; out on rising edge when out_valid && out_ready.
REQ-014 advance = !out_valid || out_ready; in_ready = advance; all stages shift only when advance=1, otherwise hold contents exactly (global stall).
REQ-015 Input accepted on edge k with advance high at k, k+1: out_valid high after edge k+2; back-to-back throughput one result per cycle.
REQ-016 Results leave in acceptance order; no loss, duplication or reordering under any out_ready pattern.
REQ-017 Bubble (in_valid=0 when advancing) propagates as invalid stage; out_result/flags with out_valid=0 are don't-care but stable while stalled.
REQ-018 Sign = sign_a XOR sign_b for all non-NaN results, including zero and infinity.
REQ-019 Exponent arithmetic in signed EXP_W+2 bits: e = ea + eb - bias, bias = 2^(EXP_W-1)-1; +1 when product MSB set.
REQ-020 Rounding round-to-nearest-even using guard, round and sticky (OR of all discarded bits); rounding carry-out renormalises and increments exponent.
REQ-021 Any NaN operand -> canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0); invalid=1 only for signalling NaN input.
REQ-022 Infinity x zero -> canonical qNaN, invalid=1.
REQ-023 Infinity x finite nonzero -> signed infinity, no flags.
REQ-024 Zero x finite -> signed zero, no flags.
REQ-025 Biased exponent after rounding >= all-ones -> signed infinity, overflow=1, inexact=1.
REQ-026 inexact=1 whenever any discarded bit nonzero or overflow/flush occurred.
REQ-027 underflow=1 when result is tiny (exponent < 1 before rounding) and inexact; exact tiny results raise no underflow.

Reset
REQ-028 nRST low clears all stage valid bits immediately; out_valid=0, out_result=0, all flags=0; in_ready=1 after release.
REQ-029 Reset mid-operation discards all in-flight operations; no result for them is ever produced.

Configuration
REQ-030 Macro FP_MUL_SUBNORMAL_EN defined: subnormal inputs use leading 0 with exponent 1; tiny results right-shifted into subnormal form (shift >= MAN_W+2 yields zero plus sticky) then rounded.
REQ-031 Macro undefined: subnormal inputs treated as signed zero; tiny results flushed to signed zero with underflow=1, inexact=1; latency unchanged.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-032 0x3FC00000 x 0x40000000, out_ready=1 -> 0x40400000, all flags 0, out_valid two edges after accept edge.
REQ-033 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0x7F800001 x 0x3F800000 -> 0x7FC00000, invalid=1.
REQ-034 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow=1, inexact=1; 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1.
REQ-035 0x00800000 x 0x3F000000 -> 0x00400000 no flags with FP_MUL_SUBNORMAL_EN; 0x00000000, underflow=1, inexact=1 without.
REQ-036 out_ready=0, in_valid held with 5 distinct operand pairs -> exactly 3 accepted, in_ready=0 from edge 2; out_ready=1 -> all 5 results in order, no gaps once flowing.
REQ-037 nRST pulsed low with 3 operations in flight -> out_valid=0 immediately, no stale result after release, next operation correct.
